// File: rtl/mem_arbiter_rr.sv
// N-port line-memory arbiter with round-robin or fixed-priority selection, one line op in flight.
// Grant 1 cycle after the request is sampled; the others stall until the owner's mem_resp plus one recover cycle.
module mem_arbiter_rr #(
  parameter int NUM_PORTS     = 2,
  parameter int LINE_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int ID_W          = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [LINE_WIDTH-1:0]            mem_wdata,
  input  logic [LINE_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_resp,
  output logic                             busy,
  output logic [ID_W-1:0]                  grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         last_q, last_d;
  logic [ID_W-1:0]         grant_id_q, grant_id_d;
  logic                    op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;

  logic [NUM_PORTS-1:0]    req_any;
  logic [ID_W-1:0]         winner;
  logic                    win_vld;

  assign req_any = req_read | req_write;

  // Scan from the far end so the highest-priority candidate is the last one written.
  always_comb begin
    int idx;
    winner  = '0;
    win_vld = 1'b0;
    idx     = 0;
    if (PRIORITY_MODE != 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req_any[i]) begin
          winner  = ID_W'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int off = NUM_PORTS; off >= 1; off--) begin
        idx = (int'(last_q) + off) % NUM_PORTS;
        if (req_any[idx]) begin
          winner  = ID_W'(idx);
          win_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (win_vld) state_d = ST_BUSY;
      ST_BUSY:    if (mem_resp) state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Capture the winner's request so later changes on its inputs cannot disturb the adaptor.
  always_comb begin
    last_d     = last_q;
    grant_id_d = grant_id_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (state_q == ST_IDLE && win_vld) begin
      grant_id_d = winner;
      if (PRIORITY_MODE == 0) last_d = winner;
      op_write_d = req_write[winner];
      addr_d     = req_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d    = req_wdata[int'(winner)*LINE_WIDTH +: LINE_WIDTH];
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = 1'b0;
    req_resp  = '0;
    case (state_q)
      ST_BUSY: begin
        mem_read  = ~op_write_q;
        mem_write = op_write_q;
        busy      = 1'b1;
        if (mem_resp) req_resp[grant_id_q] = 1'b1;
      end
      ST_RECOVER: busy = 1'b1;
      default: ;
    endcase
  end

  assign req_rdata   = mem_rdata;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign grant_id    = grant_id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= ID_W'(NUM_PORTS - 1);
      grant_id_q <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a 4-port round-robin instance and a 3-port fixed-priority instance.
module tb_mem_arbiter_rr;

  logic clk, rst;

  // 4-port round-robin instance
  logic [3:0]     a_rd, a_wr, a_resp;
  logic [127:0]   a_addr;
  logic [1023:0]  a_wdata;
  logic [255:0]   a_rdata, a_mwdata, a_mrdata;
  logic           a_mrd, a_mwr, a_mresp, a_busy;
  logic [31:0]    a_maddr;
  logic [1:0]     a_gid;

  // 3-port fixed-priority instance
  logic [2:0]     b_rd, b_wr, b_resp;
  logic [95:0]    b_addr;
  logic [767:0]   b_wdata;
  logic [255:0]   b_rdata, b_mwdata, b_mrdata;
  logic           b_mrd, b_mwr, b_mresp, b_busy;
  logic [31:0]    b_maddr;
  logic [1:0]     b_gid;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter_rr #(.NUM_PORTS(4), .LINE_WIDTH(256), .ADDR_WIDTH(32), .PRIORITY_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .req_read(a_rd), .req_write(a_wr), .req_address(a_addr),
    .req_wdata(a_wdata), .req_rdata(a_rdata), .req_resp(a_resp), .mem_read(a_mrd),
    .mem_write(a_mwr), .mem_address(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_mrdata),
    .mem_resp(a_mresp), .busy(a_busy), .grant_id(a_gid)
  );

  mem_arbiter_rr #(.NUM_PORTS(3), .LINE_WIDTH(256), .ADDR_WIDTH(32), .PRIORITY_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .req_read(b_rd), .req_write(b_wr), .req_address(b_addr),
    .req_wdata(b_wdata), .req_rdata(b_rdata), .req_resp(b_resp), .mem_read(b_mrd),
    .mem_write(b_mwr), .mem_address(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(b_mrdata),
    .mem_resp(b_mresp), .busy(b_busy), .grant_id(b_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_all();
    a_rd = '0; a_wr = '0; a_addr = '0; a_wdata = '0; a_mrdata = '0; a_mresp = 1'b0;
    b_rd = '0; b_wr = '0; b_addr = '0; b_wdata = '0; b_mrdata = '0; b_mresp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    #3;
    tests_run++; if ({a_mrd, a_mwr, a_busy} !== 3'b000) begin tests_failed++; $display("FAIL reset_ctl: got %b want 000", {a_mrd, a_mwr, a_busy}); end
    tests_run++; if (a_gid !== 2'd0) begin tests_failed++; $display("FAIL reset_gid: got %0d want 0", a_gid); end
    tests_run++; if (a_maddr !== 32'd0 || a_mwdata !== 256'd0) begin tests_failed++; $display("FAIL reset_data: got addr %h want 0", a_maddr); end
    a_mresp = 1'b1;
    #1;
    tests_run++; if (a_resp !== 4'b0000) begin tests_failed++; $display("FAIL reset_resp: got %b want 0000", a_resp); end
    tests_run++; if ({b_mrd, b_mwr, b_busy, b_gid} !== 5'b0) begin tests_failed++; $display("FAIL reset_fp: got %b want 0", {b_mrd, b_mwr, b_busy, b_gid}); end
    a_mresp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic [255:0] pat;
    pat = {64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978};
    do_reset();
    @(negedge clk);
    a_rd[1] = 1'b1;
    a_addr[32 +: 32] = 32'h0000_1000;
    #1;
    tests_run++; if (a_mrd !== 1'b0) begin tests_failed++; $display("FAIL sr_early: mem_read got %b want 0", a_mrd); end
    @(negedge clk);
    tests_run++; if (a_mrd !== 1'b1 || a_mwr !== 1'b0) begin tests_failed++; $display("FAIL sr_grant: rd/wr got %b%b want 10", a_mrd, a_mwr); end
    tests_run++; if (a_maddr !== 32'h0000_1000) begin tests_failed++; $display("FAIL sr_addr: got %h want 00001000", a_maddr); end
    tests_run++; if (a_gid !== 2'd1) begin tests_failed++; $display("FAIL sr_gid: got %0d want 1", a_gid); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++; if (a_mrd !== 1'b1 || a_resp !== 4'b0) begin tests_failed++; $display("FAIL sr_hold: rd %b resp %b want 1 0000", a_mrd, a_resp); end
    end
    @(negedge clk);
    a_mrdata = pat;
    a_mresp = 1'b1;
    #1;
    tests_run++; if (a_resp !== 4'b0010) begin tests_failed++; $display("FAIL sr_resp: got %b want 0010", a_resp); end
    tests_run++; if (a_rdata !== pat) begin tests_failed++; $display("FAIL sr_rdata: got %h want %h", a_rdata, pat); end
    a_rd = '0;
    @(negedge clk);
    a_mresp = 1'b0;
    #1;
    tests_run++; if (a_resp !== 4'b0 || a_mrd !== 1'b0 || a_busy !== 1'b1) begin tests_failed++; $display("FAIL sr_recover: resp %b rd %b busy %b want 0000 0 1", a_resp, a_mrd, a_busy); end
    @(negedge clk);
    tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL sr_idle: busy got %b want 0", a_busy); end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] last, exp_g;
    int served [4];
    bit got;
    do_reset();
    last = 2'd3;
    for (int i = 0; i < 4; i++) begin served[i] = 0; a_addr[i*32 +: 32] = 32'h100 * (i + 1); end
    @(negedge clk);
    a_rd = 4'hF;
    for (int n = 0; n < 12; n++) begin
      got = 1'b0;
      for (int w = 0; w < 6 && !got; w++) begin
        @(negedge clk);
        if (a_mrd) got = 1'b1;
      end
      tests_run++;
      if (!got) begin tests_failed++; $display("FAIL rr_timeout: no grant for txn %0d", n); break; end
      exp_g = last + 2'd1;
      last = exp_g;
      served[exp_g]++;
      tests_run++; if (a_gid !== exp_g) begin tests_failed++; $display("FAIL rr_order: txn %0d got port %0d want %0d", n, a_gid, exp_g); end
      tests_run++; if (a_maddr !== 32'h100 * (32'(exp_g) + 1)) begin tests_failed++; $display("FAIL rr_addr: got %h want %h", a_maddr, 32'h100 * (32'(exp_g) + 1)); end
      a_mresp = 1'b1;
      #1;
      tests_run++; if (a_resp !== (4'b1 << exp_g)) begin tests_failed++; $display("FAIL rr_resp: got %b want %b", a_resp, 4'b1 << exp_g); end
      @(negedge clk);
      a_mresp = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (served[i] != 3) begin tests_failed++; $display("FAIL rr_share: port %0d served %0d want 3", i, served[i]); end
    end
    a_rd = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    bit got;
    do_reset();
    @(negedge clk);
    b_rd = 3'b101;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int w = 0; w < 6 && !got; w++) begin
        @(negedge clk);
        if (b_mrd) got = 1'b1;
      end
      tests_run++;
      if (!got) begin tests_failed++; $display("FAIL fp_timeout: no grant for txn %0d", n); break; end
      tests_run++; if (b_gid !== ((n < 3) ? 2'd0 : 2'd2)) begin tests_failed++; $display("FAIL fp_winner: txn %0d got %0d want %0d", n, b_gid, (n < 3) ? 0 : 2); end
      b_mresp = 1'b1;
      #1;
      tests_run++; if (b_resp !== ((n < 3) ? 3'b001 : 3'b100)) begin tests_failed++; $display("FAIL fp_resp: got %b", b_resp); end
      if (n == 2) b_rd[0] = 1'b0;
      if (n == 3) b_rd = '0;
      @(negedge clk);
      b_mresp = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_write_capture();
    logic [255:0] wd;
    wd = {32{8'hA5}};
    do_reset();
    @(negedge clk);
    a_wr[0] = 1'b1;
    a_addr[0 +: 32] = 32'h8000_0040;
    a_wdata[0 +: 256] = wd;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++; if ({a_mrd, a_mwr} !== 2'b01) begin tests_failed++; $display("FAIL wc_op: cycle %0d rd/wr %b%b want 01", c, a_mrd, a_mwr); end
      tests_run++; if (a_maddr !== 32'h8000_0040 || a_mwdata !== wd) begin tests_failed++; $display("FAIL wc_hold: cycle %0d addr %h want 80000040", c, a_maddr); end
      a_addr[0 +: 32] = $urandom;
      a_wdata[0 +: 256] = rand_line();
      a_rd[0] = 1'b1;
    end
    @(negedge clk);
    a_mresp = 1'b1;
    #1;
    tests_run++; if (a_resp !== 4'b0001 || a_maddr !== 32'h8000_0040) begin tests_failed++; $display("FAIL wc_resp: resp %b addr %h want 0001 80000040", a_resp, a_maddr); end
    a_rd = '0; a_wr = '0;
    @(negedge clk);
    a_mresp = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    a_rd[0] = 1'b1;
    a_addr[0 +: 32] = 32'h40;
    @(negedge clk);
    tests_run++; if (a_mrd !== 1'b1 || a_gid !== 2'd0) begin tests_failed++; $display("FAIL bb_first: rd %b gid %0d want 1 0", a_mrd, a_gid); end
    a_mresp = 1'b1;
    a_rd[0] = 1'b0;
    a_rd[1] = 1'b1;
    a_addr[32 +: 32] = 32'h2000;
    #1;
    tests_run++; if (a_resp !== 4'b0001) begin tests_failed++; $display("FAIL bb_resp: got %b want 0001", a_resp); end
    @(negedge clk);
    a_mresp = 1'b0;
    tests_run++; if (a_mrd !== 1'b0 || a_busy !== 1'b1) begin tests_failed++; $display("FAIL bb_t1: rd %b busy %b want 0 1", a_mrd, a_busy); end
    @(negedge clk);
    tests_run++; if (a_mrd !== 1'b0 || a_busy !== 1'b0) begin tests_failed++; $display("FAIL bb_t2: rd %b busy %b want 0 0", a_mrd, a_busy); end
    @(negedge clk);
    tests_run++; if (a_mrd !== 1'b1 || a_gid !== 2'd1 || a_maddr !== 32'h2000) begin tests_failed++; $display("FAIL bb_t3: rd %b gid %0d addr %h want 1 1 2000", a_mrd, a_gid, a_maddr); end
    a_mresp = 1'b1;
    a_rd = '0;
    @(negedge clk);
    a_mresp = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    a_rd[2] = 1'b1;
    @(negedge clk);
    tests_run++; if (a_mrd !== 1'b1 || a_gid !== 2'd2) begin tests_failed++; $display("FAIL rm_grant: rd %b gid %0d want 1 2", a_mrd, a_gid); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if ({a_mrd, a_mwr, a_busy} !== 3'b000) begin tests_failed++; $display("FAIL rm_async: rd/wr/busy got %b want 000", {a_mrd, a_mwr, a_busy}); end
    tests_run++; if (a_gid !== 2'd0 || a_maddr !== 32'd0) begin tests_failed++; $display("FAIL rm_regs: gid %0d addr %h want 0 0", a_gid, a_maddr); end
    a_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    a_rd = 4'hF;
    @(negedge clk);
    tests_run++; if (a_mrd !== 1'b1 || a_gid !== 2'd0) begin tests_failed++; $display("FAIL rm_first: rd %b gid %0d want 1 0", a_mrd, a_gid); end
    a_rd = '0;
    a_mresp = 1'b1;
    @(negedge clk);
    a_mresp = 1'b0;
    @(negedge clk);
  endtask

  // Transaction-level reference: phase per cycle, RR winner by cyclic distance from the last grant.
  task automatic test_random();
    typedef enum {M_IDLE, M_BUSY, M_REC} mph_t;
    mph_t ph;
    int last, owner, wait_c, best, bestd, d;
    bit own_wr, resp_now;
    logic [31:0] own_addr;
    logic [255:0] own_wd, rd_line;
    logic [3:0] reqv, exp_resp;
    do_reset();
    ph = M_IDLE; last = 3; owner = 0; wait_c = 0; own_wr = 0; own_addr = '0; own_wd = '0;
    for (int it = 0; it < 500; it++) begin
      @(negedge clk);
      tests_run++; if (a_busy !== (ph != M_IDLE)) begin tests_failed++; $display("FAIL rnd_busy: it %0d got %b", it, a_busy); end
      tests_run++; if ({a_mrd, a_mwr} !== ((ph == M_BUSY) ? (own_wr ? 2'b01 : 2'b10) : 2'b00)) begin tests_failed++; $display("FAIL rnd_op: it %0d got %b%b", it, a_mrd, a_mwr); end
      if (ph == M_BUSY) begin
        tests_run++; if (a_gid !== 2'(owner)) begin tests_failed++; $display("FAIL rnd_gid: it %0d got %0d want %0d", it, a_gid, owner); end
        tests_run++; if (a_maddr !== own_addr || a_mwdata !== own_wd) begin tests_failed++; $display("FAIL rnd_cap: it %0d addr %h want %h", it, a_maddr, own_addr); end
      end
      resp_now = 1'b0;
      if (ph == M_BUSY) begin
        if (wait_c == 0) resp_now = 1'b1;
        else wait_c--;
      end else begin
        resp_now = ($urandom_range(3) == 0);
      end
      rd_line = rand_line();
      a_mresp = resp_now;
      a_mrdata = rd_line;
      #1;
      exp_resp = (ph == M_BUSY && resp_now) ? (4'b1 << owner) : 4'b0;
      tests_run++; if (a_resp !== exp_resp) begin tests_failed++; $display("FAIL rnd_resp: it %0d got %b want %b", it, a_resp, exp_resp); end
      tests_run++; if (a_rdata !== rd_line) begin tests_failed++; $display("FAIL rnd_rdata: it %0d", it); end
      if ($urandom_range(3) == 0) begin
        a_rd = '0; a_wr = '0;
      end else begin
        a_rd = 4'($urandom);
        a_wr = ($urandom_range(4) == 0) ? 4'($urandom) : 4'b0;
      end
      for (int i = 0; i < 4; i++) begin
        a_addr[i*32 +: 32] = $urandom;
        a_wdata[i*256 +: 256] = rand_line();
      end
      reqv = a_rd | a_wr;
      case (ph)
        M_IDLE: if (reqv != 0) begin
          best = -1; bestd = 99;
          for (int i = 0; i < 4; i++) begin
            d = (i + 3 - last) % 4;
            if (reqv[i] && d < bestd) begin best = i; bestd = d; end
          end
          owner = best; last = best;
          own_wr = a_wr[best];
          own_addr = a_addr[best*32 +: 32];
          own_wd = a_wdata[best*256 +: 256];
          wait_c = $urandom_range(3);
          ph = M_BUSY;
        end
        M_BUSY: if (resp_now) ph = M_REC;
        default: ph = M_IDLE;
      endcase
    end
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_fixed_priority();
    test_write_capture();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-port line-memory arbiter between the L1 caches (I$, D$, future prefetch/victim ports) and the single cacheline adaptor.
- Generalises the fixed two-port instruction/data arbiter.
- Adds a configurable port count, a selectable round-robin or fixed-priority policy, latched request capture, and grant-status outputs.
- Exactly one line transaction is outstanding downstream at any time.

Parameters:
- NUM_PORTS, 2, number of requesting ports; legal range 2..8.
- LINE_WIDTH, 256, cacheline width in bits.
- ADDR_WIDTH, 32, address width.
- PRIORITY_MODE, 0, arbitration policy: 0 = round-robin; 1 = fixed priority, with the lowest port index highest.
- ID_W, $clog2(NUM_PORTS), width of grant_id.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req_read  in  NUM_PORTS  per-port line read request.
- req_write  in  NUM_PORTS  per-port line write request.
- req_address  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line; same packing.
- req_rdata  out  LINE_WIDTH  read line, broadcast to all ports.
- req_resp  out  NUM_PORTS  per-port completion pulse.
- mem_read  out  1  read request to the adaptor.
- mem_write  out  1  write request to the adaptor.
- mem_address  out  ADDR_WIDTH  address to the adaptor.
- mem_wdata  out  LINE_WIDTH  write line to the adaptor.
- mem_rdata  in  LINE_WIDTH  read line from the adaptor.
- mem_resp  in  1  adaptor completion.
- busy  out  1  high while a transaction is owned (BUSY or RECOVER).
- grant_id  out  ID_W  index of the current or most recent owner.

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - mem_read, mem_write, req_resp, busy = 0.
  - mem_address, mem_wdata, grant_id = 0.
  - RR pointer last = NUM_PORTS-1, so port 0 wins first.
- A port is requesting when req_read[i] | req_write[i]. If both are set, the write is performed (caches never do this; defensive only).
- State IDLE:
  - If any port is requesting, the winner is computed combinationally.
  - RR mode: the first requesting index scanning last+1, last+2, … modulo NUM_PORTS.
  - Fixed mode: the lowest requesting index.
  - On the clock edge, latch op, address and wdata of the winner into capture registers; grant_id <= winner; last <= winner (RR only); go to BUSY.
- State BUSY:
  - mem_read / mem_write driven from the latched op; mem_address / mem_wdata driven from the capture registers.
  - All of these are held stable until mem_resp.
  - Grant latency: request sampled at edge t, mem_read/mem_write high from t+1.
  - Changes on the owner's request inputs during BUSY are ignored (captured values only).
- mem_resp in BUSY (same cycle, combinational):
  - req_resp[grant_id] = 1.
  - req_rdata = mem_rdata; req_rdata is continuously assigned from mem_rdata in all states.
  - Next state RECOVER; mem_read/mem_write drop at the next edge.
- State RECOVER:
  - One idle cycle with no requests and no resp, giving the owner time to deassert its request.
  - Next state IDLE.
  - Back-to-back transactions from different ports are therefore spaced: resp at cycle t, next mem_read at t+3.
- mem_resp outside BUSY: ignored; no req_resp.
- req_resp is a single-cycle pulse and is never asserted for more than one port.
- Starvation:
  - RR mode: with all ports continuously requesting, each port is granted exactly once per NUM_PORTS transactions.
  - Fixed mode: lower-index ports may starve higher-index ports, by design.
- A request withdrawn in IDLE before being sampled has no effect.
- Reset asserted mid-BUSY: transaction abandoned immediately, all outputs at reset values. The adaptor is reset by the same rst.

Test Plan:
- Single read, NUM_PORTS=2: port 1 asserts req_read with address 0x0000_1000; adaptor returns mem_resp with a known 256-bit pattern after 4 cycles.
  - Required: mem_read rises 1 cycle after the request, mem_address=0x0000_1000, req_resp=2'b10 for exactly 1 cycle, req_rdata equals the pattern, grant_id=1.
- RR fairness, NUM_PORTS=4, PRIORITY_MODE=0: all 4 ports hold reads continuously.
  - Required: grant order 0,1,2,3,0,1…; no port served twice before every port has been served once.
- Fixed priority, PRIORITY_MODE=1: ports 0 and 2 request continuously.
  - Required: port 0 wins every arbitration; port 2 is granted only after port 0 drops.
- Write capture: port 0 writes address 0x8000_0040 with wdata=all-0xA5; the bench changes req_address/req_wdata while BUSY.
  - Required: mem_address and mem_wdata stay at the captured values until mem_resp; mem_write=1, mem_read=0.
- Simultaneous request at resp: port 1 requests while port 0 receives mem_resp.
  - Required: RECOVER for 1 cycle, then port 1 granted; mem_read rises 3 cycles after the earlier resp.
- Reset mid-transaction: assert rst during BUSY, between clock edges.
  - Required: mem_read/mem_write/busy fall asynchronously; after release, grant_id=0 and the first winner is port 0 in RR mode.
